// File: rtl/vpu_fp_max_reduce_if.sv
// Handshake bundle between the max-reduce sequencer and its neighbours:
// job source, element stream, shared FP max unit and result sink.
interface vpu_fp_max_reduce_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 6
);
    logic                  job_valid_i;
    logic                  job_ready_o;
    logic [LEN_WIDTH-1:0]  job_len_i;
    logic                  elem_valid_i;
    logic                  elem_ready_o;
    logic [DATA_WIDTH-1:0] elem_data_i;
    logic                  max_start_o;
    logic [DATA_WIDTH-1:0] max_op0_o;
    logic [DATA_WIDTH-1:0] max_op1_o;
    logic                  max_done_i;
    logic [DATA_WIDTH-1:0] max_result_i;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [DATA_WIDTH-1:0] res_data_o;
    logic                  busy_o;

    // master is the sequencer side
    modport master (
        input  job_valid_i, job_len_i, elem_valid_i, elem_data_i,
               max_done_i, max_result_i, res_ready_i,
        output job_ready_o, elem_ready_o, max_start_o, max_op0_o, max_op1_o,
               res_valid_o, res_data_o, busy_o
    );

    modport slave (
        output job_valid_i, job_len_i, elem_valid_i, elem_data_i,
               max_done_i, max_result_i, res_ready_i,
        input  job_ready_o, elem_ready_o, max_start_o, max_op0_o, max_op1_o,
               res_valid_o, res_data_o, busy_o
    );
endinterface

// File: rtl/vpu_fp_max_reduce_ctrl.sv
// Max-reduction sequencer: folds a streamed vector into acc through one shared
// 2-input FP max unit, one op in flight, no arithmetic on data locally.
module vpu_fp_max_reduce_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    vpu_fp_max_reduce_if.master   bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                state, state_n;
    logic [LEN_WIDTH-1:0]  rem, rem_n;
    logic [DATA_WIDTH-1:0] acc, acc_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rem   <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            acc   <= acc_n;
        end
    end

    always_comb begin
        state_n          = state;
        rem_n            = rem;
        acc_n            = acc;
        bus.job_ready_o  = 1'b0;
        bus.elem_ready_o = 1'b0;
        bus.max_start_o  = 1'b0;
        bus.max_op0_o    = acc;
        bus.max_op1_o    = '0;
        bus.res_valid_o  = 1'b0;
        bus.res_data_o   = acc;
        bus.busy_o       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                bus.job_ready_o = 1'b1;
                if (bus.job_valid_i) begin
                    rem_n = bus.job_len_i;
                    if (bus.job_len_i == '0) begin
                        acc_n   = '0;
                        state_n = S_DONE;
                    end else begin
                        state_n = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                bus.elem_ready_o = 1'b1;
                if (bus.elem_valid_i) begin
                    acc_n   = bus.elem_data_i;
                    rem_n   = rem - LEN_WIDTH'(1);
                    state_n = (rem == LEN_WIDTH'(1)) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // the unit samples both operands on the start cycle itself
                bus.elem_ready_o = 1'b1;
                bus.max_op1_o    = bus.elem_data_i;
                if (bus.elem_valid_i) begin
                    bus.max_start_o = 1'b1;
                    state_n         = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.max_done_i) begin
                    acc_n   = bus.max_result_i;
                    rem_n   = rem - LEN_WIDTH'(1);
                    state_n = (rem == LEN_WIDTH'(1)) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                bus.res_valid_o = 1'b1;
                if (bus.res_ready_i) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_vpu_fp_max_reduce_ctrl.sv
// Bench for the max-reduce sequencer: table vectors, hand-built corner
// sequences and random jobs against a sort-based reference.
module tb_vpu_fp_max_reduce_ctrl;
    localparam int DW = 16;
    localparam int LW = 6;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vpu_fp_max_reduce_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();
    vpu_fp_max_reduce_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int n_erdy = 0;
    logic [15:0] sq0[$];
    logic [15:0] sq1[$];
    logic [15:0] jq[$];

    int          dcnt = 0;
    logic [15:0] mres = '0;
    logic        frc_done = 1'b0;
    logic [15:0] frc_res = '0;

    function automatic logic [15:0] key(input logic [15:0] a);
        return a[15] ? ~a : (a ^ 16'h8000);
    endfunction
    function automatic logic [15:0] unkey(input logic [15:0] k);
        return k[15] ? (k ^ 16'h8000) : ~k;
    endfunction
    function automatic logic [15:0] fmax(input logic [15:0] a, input logic [15:0] b);
        return (key(b) > key(a)) ? b : a;
    endfunction
    function automatic logic [15:0] rnd_bf();
        logic [15:0] v;
        v = 16'($urandom);
        if (v[14:7] == 8'hFF) v[14] = 1'b0;
        return v;
    endfunction

    // Max unit model: fixed latency L, result is the ordered max.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) dcnt <= 0;
        else if (bus.max_start_o) begin
            dcnt <= L;
            mres <= fmax(bus.max_op0_o, bus.max_op1_o);
        end else if (dcnt != 0) dcnt <= dcnt - 1;
    end
    assign bus.max_done_i   = (dcnt == 1) | frc_done;
    assign bus.max_result_i = frc_done ? frc_res : mres;

    always @(negedge clk) begin
        if (bus.job_valid_i && bus.job_ready_o) hs_cyc = cyc;
        if (bus.elem_ready_o) n_erdy++;
        if (bus.max_start_o) begin
            sq0.push_back(bus.max_op0_o);
            sq1.push_back(bus.max_op1_o);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout", nm);
    endtask

    // All driver tasks start and end at posedge+1.
    task automatic start_job(input int len);
        int ok = 0;
        bus.job_valid_i = 1'b1;
        bus.job_len_i   = LW'(len);
        for (int k = 0; k < 100 && ok == 0; k++) begin
            @(negedge clk);
            if (bus.job_ready_o) ok = 1;
            @(posedge clk); #1;
        end
        bus.job_valid_i = 1'b0;
        if (ok == 0) tmo("job_accept");
    endtask

    task automatic send_elem(input logic [15:0] d);
        int ok = 0;
        bus.elem_valid_i = 1'b1;
        bus.elem_data_i  = d;
        for (int k = 0; k < 100 && ok == 0; k++) begin
            @(negedge clk);
            if (bus.elem_ready_o) ok = 1;
            @(posedge clk); #1;
        end
        bus.elem_valid_i = 1'b0;
        bus.elem_data_i  = '0;
        if (ok == 0) tmo("elem_accept");
    endtask

    task automatic wait_res(input logic [15:0] exp_res, input int exp_lat);
        int ok = 0;
        for (int k = 0; k < 400 && ok == 0; k++) begin
            @(negedge clk);
            if (bus.res_valid_o) ok = 1;
        end
        if (ok == 0) tmo("res_valid");
        else begin
            chk("res_data", bus.res_data_o, exp_res);
            if (exp_lat >= 0) chk("latency", cyc - hs_cyc, exp_lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_starts(input int s0, input int len);
        chk("start_count", sq0.size() - s0, (len > 1) ? len - 1 : 0);
        if (len >= 2 && sq0.size() > s0) begin
            chk("first_op0", sq0[s0], jq[0]);
            chk("first_op1", sq1[s0], jq[1]);
        end
    endtask

    task automatic run_job(input int len, input int gap, input int exp_lat, input logic [15:0] exp_res);
        int s0 = sq0.size();
        int r0 = n_erdy;
        start_job(len);
        for (int i = 0; i < len; i++) begin
            send_elem(jq[i]);
            if (gap > 0 && i + 1 < len) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        wait_res(exp_res, exp_lat);
        check_starts(s0, len);
        if (len == 0) chk("len0_no_elem_ready", n_erdy - r0, 0);
    endtask

    function automatic logic [15:0] ref_res();
        logic [15:0] kq[$];
        if (jq.size() == 0) return 16'h0000;
        foreach (jq[i]) kq.push_back(key(jq[i]));
        kq.sort();
        return unkey(kq[kq.size() - 1]);
    endfunction

    typedef struct packed {
        logic [6:0]       len;
        logic [4:0][15:0] e;
        logic [15:0]      res;
        logic [7:0]       lat;
    } vec_t;

    function automatic vec_t mkv(input int len, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d, input logic [15:0] f,
                                 input logic [15:0] res, input int lat);
        vec_t v;
        v.len = 7'(len);
        v.e[0] = a; v.e[1] = b; v.e[2] = c; v.e[3] = d; v.e[4] = f;
        v.res = res;
        v.lat = 8'(lat);
        return v;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int   s0;
        int   hs_exp;
        vt[0] = mkv(4, 16'h3F80, 16'hC000, 16'h4040, 16'h4000, 16'h0, 16'h4040, 11);
        vt[1] = mkv(1, 16'hBF80, 16'h0,    16'h0,    16'h0,    16'h0, 16'hBF80, 2);
        vt[2] = mkv(0, 16'h0,    16'h0,    16'h0,    16'h0,    16'h0, 16'h0000, 1);
        vt[3] = mkv(2, 16'h4000, 16'h3F80, 16'h0,    16'h0,    16'h0, 16'h4000, 5);
        vt[4] = mkv(3, 16'hC000, 16'hBF80, 16'hC040, 16'h0,    16'h0, 16'hBF80, 8);
        vt[5] = mkv(5, 16'h0000, 16'h8000, 16'h3C00, 16'h4100, 16'h3F00, 16'h4100, 14);

        bus.job_valid_i  = 1'b0;
        bus.job_len_i    = '0;
        bus.elem_valid_i = 1'b0;
        bus.elem_data_i  = '0;
        bus.res_ready_i  = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_job_ready", bus.job_ready_o, 1);
        chk("rst_elem_ready", bus.elem_ready_o, 0);
        chk("rst_max_start", bus.max_start_o, 0);
        chk("rst_res_valid", bus.res_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_res_data", bus.res_data_o, 0);
        chk("rst_op0", bus.max_op0_o, 0);
        chk("rst_op1", bus.max_op1_o, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            jq.delete();
            for (int j = 0; j < int'(vt[i].len); j++) jq.push_back(vt[i].e[j]);
            run_job(int'(vt[i].len), 0, int'(vt[i].lat), vt[i].res);
        end

        // Result backpressure: DONE holds, new job waits for the drain.
        jq = '{16'h4000, 16'hC000, 16'h3F80};
        bus.res_ready_i = 1'b0;
        start_job(3);
        foreach (jq[i]) send_elem(jq[i]);
        begin
            int ok = 0;
            for (int k = 0; k < 100 && ok == 0; k++) begin
                @(negedge clk);
                if (bus.res_valid_o) ok = 1;
            end
            if (ok == 0) tmo("hold_res_valid");
        end
        bus.job_valid_i = 1'b1;
        bus.job_len_i   = LW'(1);
        for (int k = 0; k < 5; k++) begin
            chk("hold_res_valid", bus.res_valid_o, 1);
            chk("hold_res_data", bus.res_data_o, 16'h4000);
            chk("hold_job_ready", bus.job_ready_o, 0);
            @(negedge clk);
        end
        bus.res_ready_i = 1'b1;
        chk("hold_res_data_last", bus.res_data_o, 16'h4000);
        @(negedge clk);
        chk("next_job_ready", bus.job_ready_o, 1);
        hs_exp = cyc;
        @(posedge clk); #1;
        bus.job_valid_i = 1'b0;
        chk("next_job_accept_cycle", hs_cyc, hs_exp);
        jq = '{16'hBF80};
        send_elem(jq[0]);
        wait_res(16'hBF80, -1);

        // Reset while a max op is outstanding; its late done is ignored.
        jq = '{16'h3F80, 16'h4000, 16'h4040};
        start_job(3);
        send_elem(jq[0]);
        send_elem(jq[1]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_job_ready", bus.job_ready_o, 1);
        chk("midrst_busy", bus.busy_o, 0);
        chk("midrst_acc", bus.max_op0_o, 0);
        frc_res  = 16'h7F80;
        frc_done = 1'b1;
        @(posedge clk); #1;
        frc_done = 1'b0;
        @(negedge clk);
        chk("late_done_job_ready", bus.job_ready_o, 1);
        chk("late_done_acc", bus.max_op0_o, 0);
        chk("late_done_res_valid", bus.res_valid_o, 0);
        @(posedge clk); #1;
        jq = '{16'h4000, 16'h3F80};
        run_job(2, 0, 5, 16'h4000);

        // Spurious done in IDLE and ISSUE, elements gapped by 3 cycles.
        frc_done = 1'b1;
        @(posedge clk); #1;
        frc_done = 1'b0;
        @(negedge clk);
        chk("spur_idle_job_ready", bus.job_ready_o, 1);
        chk("spur_idle_acc", bus.max_op0_o, 16'h4000);
        @(posedge clk); #1;
        jq = '{16'hC040, 16'h3F80, 16'h4100, 16'hBF00};
        s0 = sq0.size();
        start_job(4);
        send_elem(jq[0]);
        frc_done = 1'b1;
        @(posedge clk); #1;
        frc_done = 1'b0;
        @(negedge clk);
        chk("spur_issue_acc", bus.max_op0_o, 16'hC040);
        chk("spur_issue_elem_ready", bus.elem_ready_o, 1);
        chk("spur_issue_busy", bus.busy_o, 1);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i < 4; i++) begin
            send_elem(jq[i]);
            if (i < 3) begin
                repeat (3) @(posedge clk);
                #1;
            end
        end
        wait_res(16'h4100, -1);
        check_starts(s0, 4);

        // Random jobs against a sort-based reference, ending with the max length.
        for (int n = 0; n < 26; n++) begin
            int len;
            int gap;
            int lat;
            len = (n == 25) ? 63 : int'($urandom_range(0, 9));
            gap = int'($urandom_range(0, 2));
            jq.delete();
            for (int j = 0; j < len; j++) jq.push_back(rnd_bf());
            if (gap != 0) lat = -1;
            else if (len == 0) lat = 1;
            else lat = 2 + (1 + L) * (len - 1);
            run_job(len, gap, lat, ref_res());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
